// File: rtl/nx_axi4s_unpacker_if.sv
// Bundle for the slot-packed AXI4-stream input and the single-message output stream
// of nx_axi4s_unpacker. The slave modport is the unpacker's view.
interface nx_axi4s_unpacker_if #(
  parameter int AXI4_DATA_WIDTH = 64,
  parameter int MSG_WIDTH       = 31
);
  logic [AXI4_DATA_WIDTH-1:0] axi4s_tdata;
  logic                       axi4s_tlast;
  logic                       axi4s_tvalid;
  logic                       axi4s_tready;
  logic [MSG_WIDTH-1:0]       msg_data;
  logic                       msg_last;
  logic                       msg_valid;
  logic                       msg_ready;

  modport master (
    output axi4s_tdata, axi4s_tlast, axi4s_tvalid,
    input  axi4s_tready,
    input  msg_data, msg_last, msg_valid,
    output msg_ready
  );

  modport slave (
    input  axi4s_tdata, axi4s_tlast, axi4s_tvalid,
    output axi4s_tready,
    output msg_data, msg_last, msg_valid,
    input  msg_ready
  );
endinterface

// File: rtl/nx_axi4s_unpacker.sv
// Unpacks slot-packed AXI4-stream beats into single messages, lowest present slot first.
// Optional NX_AXI4S_UNPACK_PIPE_EN: accept the next beat on the edge the current one drains.
module nx_axi4s_unpacker #(
  parameter int AXI4_DATA_WIDTH = 64,
  parameter int MSG_WIDTH       = 31
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  nx_axi4s_unpacker_if.slave   bus,
  input  logic                 i_err_clr,
  output logic [1:0]           o_err,
  output logic [31:0]          o_msg_count
);
  localparam int SLOT_WIDTH = MSG_WIDTH + 1;
  localparam int A2N_RATIO  = AXI4_DATA_WIDTH / SLOT_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  logic [0:0]           state_reg;
  logic [A2N_RATIO-1:0] mask_reg;
  logic                 last_reg;
  logic [MSG_WIDTH-1:0] slot_reg [A2N_RATIO];
  logic [MSG_WIDTH-1:0] msg_data_reg;
  logic                 msg_last_reg;
  logic                 msg_valid_reg;
  logic [1:0]           err_reg;
  logic [31:0]          count_reg;

  logic [A2N_RATIO-1:0] in_mask;
  logic [A2N_RATIO-1:0] in_mask_inc;
  logic [MSG_WIDTH-1:0] in_data [A2N_RATIO];
  logic [A2N_RATIO-1:0] mask_after;
  logic [MSG_WIDTH-1:0] sel_data_next;
  logic                 advance;
  logic                 release_beat;
  logic                 tready;
  logic                 hs;
  logic                 in_empty;
  logic                 in_gap;
  logic [1:0]           err_set;

  generate
    for (genvar gi = 0; gi < A2N_RATIO; gi++) begin : g_slot
      assign in_mask[gi] = bus.axi4s_tdata[(gi+1)*SLOT_WIDTH-1];
      assign in_data[gi] = bus.axi4s_tdata[gi*SLOT_WIDTH +: MSG_WIDTH];
    end
  endgenerate

  // m & (m-1) drops the lowest set bit: that slot is the one being delivered.
  assign mask_after = mask_reg & (mask_reg - A2N_RATIO'(1));

  always_comb begin
    sel_data_next = '0;
    for (int i = A2N_RATIO - 1; i >= 0; i--) begin
      if (mask_reg[i]) sel_data_next = slot_reg[i];
    end
  end

  assign advance      = !msg_valid_reg || bus.msg_ready;
  assign release_beat = (state_reg == ST_DRAIN) && advance && (mask_after == '0);

`ifdef NX_AXI4S_UNPACK_PIPE_EN
  assign tready = (state_reg == ST_IDLE) || release_beat;
`else
  assign tready = (state_reg == ST_IDLE);
`endif

  assign hs          = bus.axi4s_tvalid && tready;
  assign in_empty    = (in_mask == '0);
  // A contiguous-from-slot-0 mask plus one is a power of two, so this is zero only without gaps.
  assign in_mask_inc = in_mask + A2N_RATIO'(1);
  assign in_gap      = ((in_mask & in_mask_inc) != '0);
  assign err_set     = hs ? {in_gap, in_empty} : 2'b00;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      mask_reg      <= '0;
      last_reg      <= 1'b0;
      msg_data_reg  <= '0;
      msg_last_reg  <= 1'b0;
      msg_valid_reg <= 1'b0;
      err_reg       <= 2'b00;
      count_reg     <= '0;
      for (int i = 0; i < A2N_RATIO; i++) slot_reg[i] <= '0;
    end else begin
      if (advance) begin
        if (state_reg == ST_DRAIN) begin
          msg_data_reg  <= sel_data_next;
          msg_valid_reg <= 1'b1;
          msg_last_reg  <= last_reg && (mask_after == '0);
          mask_reg      <= mask_after;
        end else begin
          msg_valid_reg <= 1'b0;
        end
      end

      // Capture overrides the release above when both land on the same edge.
      if (hs && !in_empty) begin
        state_reg <= ST_DRAIN;
        mask_reg  <= in_mask;
        last_reg  <= bus.axi4s_tlast;
        slot_reg  <= in_data;
      end else if (release_beat) begin
        state_reg <= ST_IDLE;
      end

      if (i_err_clr && (err_set == 2'b00)) err_reg <= 2'b00;
      else                                 err_reg <= err_reg | err_set;

      if (msg_valid_reg && bus.msg_ready) count_reg <= count_reg + 32'd1;
    end
  end

  assign bus.axi4s_tready = tready;
  assign bus.msg_data     = msg_data_reg;
  assign bus.msg_last     = msg_last_reg;
  assign bus.msg_valid    = msg_valid_reg;
  assign o_err            = err_reg;
  assign o_msg_count      = count_reg;
endmodule

// File: tb/tb_nx_axi4s_unpacker.sv
// Directed bench for nx_axi4s_unpacker with a queue-based reference model of the message stream.
module tb_nx_axi4s_unpacker;
  localparam int DW = 64;
  localparam int MW = 31;
  localparam int SW = MW + 1;
  localparam int NS = DW / SW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        err_clr = 1'b0;
  logic [1:0]  err;
  logic [31:0] cnt;

  nx_axi4s_unpacker_if #(.AXI4_DATA_WIDTH(DW), .MSG_WIDTH(MW)) bus ();

  nx_axi4s_unpacker #(.AXI4_DATA_WIDTH(DW), .MSG_WIDTH(MW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .i_err_clr   (err_clr),
    .o_err       (err),
    .o_msg_count (cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [MW-1:0] d;
    logic          l;
  } msg_t;

  msg_t        exp_q[$];
  logic [1:0]  m_err;
  logic [31:0] m_cnt;

  logic          s_hs, s_tlast, s_vr, s_clr;
  logic [DW-1:0] s_tdata;

  bit win_en = 0;
  int cyc = 0, win_first = 0, win_last = 0, win_n = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: every accepted beat appends its present slots, in slot order, to exp_q.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_err <= 2'b00;
      m_cnt <= '0;
    end else begin
      logic [1:0] nerr;
      int top;
      bit absent_seen;
      msg_t m;
      nerr = 2'b00;
      if (s_vr) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_cnt <= m_cnt + 32'd1;
      end
      if (s_hs) begin
        top = -1;
        absent_seen = 0;
        for (int i = 0; i < NS; i++) begin
          if (s_tdata[(i+1)*SW-1]) begin
            top = i;
            if (absent_seen) nerr[1] = 1'b1;
          end else begin
            absent_seen = 1;
          end
        end
        if (top < 0) nerr[0] = 1'b1;
        for (int i = 0; i < NS; i++) begin
          if (s_tdata[(i+1)*SW-1]) begin
            m.d = s_tdata[i*SW +: MW];
            m.l = s_tlast && (i == top);
            exp_q.push_back(m);
          end
        end
      end
      if (s_clr && nerr == 2'b00) m_err <= 2'b00;
      else                        m_err <= m_err | nerr;
    end
  end

  // Compare against the model each cycle, then snapshot the handshakes the coming edge will see.
  always @(negedge clk) begin
    if (rst_n) begin
      check("err", {62'd0, err}, {62'd0, m_err});
      check("msg_count", {32'd0, cnt}, {32'd0, m_cnt});
      if (bus.msg_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL msg_unexpected: got data 0x%0h, expected no message at %0t", bus.msg_data, $time);
        end else begin
          check("msg_data", {33'd0, bus.msg_data}, {33'd0, exp_q[0].d});
          check("msg_last", {63'd0, bus.msg_last}, {63'd0, exp_q[0].l});
        end
      end
      if (win_en && bus.msg_valid && bus.msg_ready) begin
        if (win_n == 0) win_first <= cyc;
        win_last <= cyc;
        win_n    <= win_n + 1;
      end
    end
    cyc     <= cyc + 1;
    s_hs    <= rst_n && bus.axi4s_tvalid && bus.axi4s_tready;
    s_tdata <= bus.axi4s_tdata;
    s_tlast <= bus.axi4s_tlast;
    s_vr    <= rst_n && bus.msg_valid && bus.msg_ready;
    s_clr   <= err_clr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a beat; returns 1 ns after the accepting edge (cycle T+1).
  task automatic drive_beat(input logic [DW-1:0] data, input logic last, input bit hold);
    int n;
    bus.axi4s_tdata  = data;
    bus.axi4s_tlast  = last;
    bus.axi4s_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.axi4s_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL tready_timeout: got tready=0 for 50 cycles, expected 1");
    end
    tick();
    if (!hold) bus.axi4s_tvalid = 1'b0;
  endtask

  function automatic logic [DW-1:0] full_beat(input logic [MW-1:0] d0, input logic [MW-1:0] d1);
    return {1'b1, d1, 1'b1, d0};
  endfunction

  initial begin
    bus.axi4s_tdata  = '0;
    bus.axi4s_tlast  = 1'b0;
    bus.axi4s_tvalid = 1'b0;
    bus.msg_ready    = 1'b1;

    // Reset asserted mid-clock: outputs clear without waiting for an edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid", {63'd0, bus.msg_valid}, 64'd0);
    check("rst_data", {33'd0, bus.msg_data}, 64'd0);
    check("rst_last", {63'd0, bus.msg_last}, 64'd0);
    check("rst_err", {62'd0, err}, 64'd0);
    check("rst_count", {32'd0, cnt}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("tready_after_rst", {63'd0, bus.axi4s_tready}, 64'd1);
    tick();

    // Two-slot beat, ready high: T+2 and T+3.
    drive_beat(full_beat(31'h0AAA, 31'h0BBB), 1'b1, 0);
    tick();
    check("b1_s0_data", {33'd0, bus.msg_data}, 64'h0AAA);
    check("b1_s0_last", {62'd0, bus.msg_valid, bus.msg_last}, 64'b10);
    tick();
    check("b1_s1_data", {33'd0, bus.msg_data}, 64'h0BBB);
    check("b1_s1_last", {62'd0, bus.msg_valid, bus.msg_last}, 64'b11);
    tick();
    check("b1_count", {32'd0, cnt}, 64'd2);
    check("b1_err", {62'd0, err}, 64'd0);

    // Backpressure: first slot held for five cycles with the input closed.
    bus.msg_ready = 1'b0;
    drive_beat(full_beat(31'h0AAA, 31'h0BBB), 1'b1, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_data", {32'd0, bus.msg_valid, bus.msg_data}, {32'd0, 1'b1, 31'h0AAA});
      check("bp_tready", {63'd0, bus.axi4s_tready}, 64'd0);
    end
    tick();
    bus.msg_ready = 1'b1;
    tick();
    check("bp_s1_data", {31'd0, bus.msg_valid, bus.msg_last, bus.msg_data}, {31'd0, 2'b11, 31'h0BBB});
    tick();
    check("bp_count", {32'd0, cnt}, 64'd4);

    // Gap beat (slot 1 only), then an empty beat, then a clear.
    drive_beat({1'b1, 31'h0123, 32'h0}, 1'b0, 0);
    check("gap_err", {62'd0, err}, 64'b10);
    tick();
    check("gap_msg", {31'd0, bus.msg_valid, bus.msg_last, bus.msg_data}, {31'd0, 2'b10, 31'h0123});
    tick();
    drive_beat('0, 1'b1, 0);
    check("empty_err", {62'd0, err}, 64'b11);
    check("empty_valid", {63'd0, bus.msg_valid}, 64'd0);
    tick();
    check("empty_count", {32'd0, cnt}, 64'd5);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_clr", {62'd0, err}, 64'd0);

    // Four back-to-back full beats.
    win_en = 1;
    for (int b = 0; b < 4; b++) begin
      drive_beat(full_beat(31'(32'h100 + 2*b), 31'(32'h101 + 2*b)), (b == 3), 1);
    end
    bus.axi4s_tvalid = 1'b0;
    repeat (10) tick();
    win_en = 0;
    check("b2b_msgs", 64'(win_n), 64'd8);
`ifdef NX_AXI4S_UNPACK_PIPE_EN
    check("b2b_span", 64'(win_last - win_first), 64'd7);
`else
    // One empty output cycle between consecutive beats: 8 messages + 3 bubbles.
    check("b2b_span", 64'(win_last - win_first), 64'd10);
`endif
    check("b2b_count", {32'd0, cnt}, 64'd13);

    // Reset while slot 1 of a held beat is still pending.
    bus.msg_ready = 1'b0;
    drive_beat(full_beat(31'h0777, 31'h0888), 1'b1, 0);
    tick();
    check("pre_rst_data", {32'd0, bus.msg_valid, bus.msg_data}, {32'd0, 1'b1, 31'h0777});
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", {63'd0, bus.msg_valid}, 64'd0);
    check("midrst_count", {32'd0, cnt}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.msg_ready = 1'b1;
    @(negedge clk);
    check("midrst_tready", {63'd0, bus.axi4s_tready}, 64'd1);
    repeat (10) tick();
    check("midrst_no_msg", {63'd0, bus.msg_valid}, 64'd0);
    check("midrst_count_after", {32'd0, cnt}, 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
